// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and constants for the receive frame controller
//
// Purpose: FSM state encoding, broadcast address, minimum frame length and
// the saturating increment used by the drop counters.
`timescale 1ns/1ps

package rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEST  = 3'd1,
    RECV  = 3'd2,
    CHECK = 3'd3,
    HOLD  = 3'd4,
    SKIP  = 3'd5,
    DROP  = 3'd6
  } rx_state_t;

  localparam logic [7:0] BCAST   = 8'h2A;
  localparam int         MIN_LEN = 3;

  // Drop counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_frame_buf.sv
// rtl/rx_frame_buf.sv - single-frame byte buffer with registered read port
//
// Purpose: DEPTH x 8 RAM, one write port and one read port.
// Ports:
//   clk, reset        clock, synchronous active-low reset (read register only)
//   wr_en/waddr/wdata byte write, committed on the same clk edge
//   rd_en/raddr       read request; rdata updates on the next edge
//   rdata             registered read data, 0 after reset
`timescale 1ns/1ps

module rx_frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:DEPTH-1];

  // Storage is intentionally not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= 8'h00;
    end else if (rd_en) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - receive frame sequencer: address filter, buffer, host handoff
//
// Purpose: filters frames on destination address, stores one frame, checks
// length/error status and hands the frame to the host byte by byte. Bad
// frames and frames arriving while a frame is held are dropped and counted.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   cardet, SFD    carrier detect / frame-receive state from the receiver
//   write, data    received byte strobe and value
//   error          receiver error indication
//   rrdy, rrd      frame available / host read strobe
//   rdata          registered buffer byte at the read pointer
//   rlen           accepted frame length
//   rsrc, rtype    source address and type byte of the held frame
//   err_cnt        saturating count of dropped bad frames
//   ovf_cnt        saturating count of frames dropped while busy
`timescale 1ns/1ps

module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter logic [7:0] MAC_ADDR  = 8'h07,
  parameter int         BUF_DEPTH = 64,
  parameter int         LW        = $clog2(BUF_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cardet,
  input  logic          SFD,
  input  logic          write,
  input  logic [7:0]    data,
  input  logic          error,
  output logic          rrdy,
  input  logic          rrd,
  output logic [7:0]    rdata,
  output logic [LW-1:0] rlen,
  output logic [7:0]    rsrc,
  output logic [7:0]    rtype,
  output logic [7:0]    err_cnt,
  output logic [7:0]    ovf_cnt
);

  localparam int            AW       = $clog2(BUF_DEPTH);
  localparam logic [LW-1:0] DEPTH_L  = LW'(BUF_DEPTH);
  localparam logic [LW-1:0] MIN_L    = LW'(MIN_LEN);
  localparam logic [LW-1:0] ONE_L    = LW'(1);
  localparam logic [LW-1:0] TWO_L    = LW'(2);

  rx_state_t     state, next_state;
  logic          sfd_d;
  logic          sfd_rise, sfd_fall;
  logic [LW-1:0] wptr, rptr;

  logic store;
  logic wptr_clr;
  logic load_len;
  logic rd_adv;
  logic err_inc;
  logic ovf_inc;
  logic addr_match;

  assign sfd_rise   = SFD & ~sfd_d;
  assign sfd_fall   = ~SFD & sfd_d;
  assign addr_match = (data == MAC_ADDR) || (data == BCAST);
  assign rrdy       = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    store      = 1'b0;
    wptr_clr   = 1'b0;
    load_len   = 1'b0;
    rd_adv     = 1'b0;
    err_inc    = 1'b0;
    ovf_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sfd_rise) begin
          wptr_clr   = 1'b1;
          next_state = DEST;
        end
      end
      DEST: begin
        if (error) begin
          err_inc    = 1'b1;
          next_state = DROP;
        end else if (write) begin
          if (addr_match) begin
            store = 1'b1;
            // A one-byte frame that ends here still goes through CHECK.
            next_state = sfd_fall ? CHECK : RECV;
          end else begin
            next_state = SKIP;
          end
        end else if (sfd_fall) begin
          next_state = CHECK;
        end
      end
      RECV: begin
        // Error beats a simultaneous write; a write past a full buffer
        // drops the frame; otherwise a write alongside the SFD fall is
        // stored before the length check.
        if (error) begin
          err_inc    = 1'b1;
          next_state = DROP;
        end else if (write && (wptr == DEPTH_L)) begin
          err_inc    = 1'b1;
          next_state = DROP;
        end else begin
          store = write;
          if (sfd_fall) begin
            next_state = CHECK;
          end
        end
      end
      CHECK: begin
        if (wptr < MIN_L) begin
          err_inc    = 1'b1;
          next_state = IDLE;
        end else begin
          load_len   = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (sfd_rise) begin
          ovf_inc = 1'b1;
        end
        if (rrd) begin
          rd_adv = 1'b1;
          if (rptr == (rlen - ONE_L)) begin
            next_state = IDLE;
          end
        end
      end
      SKIP, DROP: begin
        if (!SFD && !cardet) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sfd_d   <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      rlen    <= '0;
      rsrc    <= 8'h00;
      rtype   <= 8'h00;
      err_cnt <= 8'h00;
      ovf_cnt <= 8'h00;
    end else begin
      sfd_d <= SFD;
      if (wptr_clr) begin
        wptr <= '0;
      end else if (store) begin
        wptr <= wptr + ONE_L;
      end
      if (store && (wptr == ONE_L)) begin
        rsrc <= data;
      end
      if (store && (wptr == TWO_L)) begin
        rtype <= data;
      end
      if (load_len) begin
        rlen <= wptr;
        rptr <= '0;
      end else if (rd_adv) begin
        rptr <= (next_state == IDLE) ? '0 : rptr + ONE_L;
      end
      if (err_inc) begin
        err_cnt <= sat_inc8(err_cnt);
      end
      if (ovf_inc) begin
        ovf_cnt <= sat_inc8(ovf_cnt);
      end
    end
  end

  rx_frame_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .wr_en (store),
    .waddr (wptr[AW-1:0]),
    .wdata (data),
    .rd_en (state == HOLD),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - self-checking bench for rx_frame_ctrl
`timescale 1ns/1ps

module tb_rx_frame_ctrl;

  localparam int         DEPTH = 64;
  localparam int         LW    = $clog2(DEPTH) + 1;
  localparam logic [7:0] MAC   = 8'h07;
  localparam logic [7:0] BC    = 8'h2A;
  localparam int         MINL  = 3;

  logic          clk = 1'b0;
  logic          reset, cardet, SFD, write, error, rrd;
  logic [7:0]    data;
  logic          rrdy;
  logic [7:0]    rdata, rsrc, rtype, err_cnt, ovf_cnt;
  logic [LW-1:0] rlen;

  rx_frame_ctrl #(.MAC_ADDR(MAC), .BUF_DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset), .cardet(cardet), .SFD(SFD), .write(write),
    .data(data), .error(error), .rrdy(rrdy), .rrd(rrd), .rdata(rdata),
    .rlen(rlen), .rsrc(rsrc), .rtype(rtype), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit settled = 1'b0;

  // Frame-level model state
  logic [7:0] fr[$];
  logic [7:0] held[$];
  logic       exp_rrdy = 1'b0;
  logic [7:0] exp_err = 8'h00, exp_ovf = 8'h00, exp_rsrc = 8'h00, exp_rtype = 8'h00;
  int         exp_rlen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Outcome of a complete frame decided from the acceptance rules only.
  task automatic model_frame(input int err_at);
    if (exp_rrdy) begin
      exp_ovf = sat8(exp_ovf);
    end else if (fr.size() > 0 && (fr[0] == MAC || fr[0] == BC)) begin
      if (err_at >= 0 || fr.size() > DEPTH || fr.size() < MINL) begin
        exp_err = sat8(exp_err);
      end else begin
        held      = fr;
        exp_rrdy  = 1'b1;
        exp_rlen  = fr.size();
        exp_rsrc  = fr[1];
        exp_rtype = fr[2];
      end
    end
  endtask

  task automatic model_reset();
    exp_rrdy = 1'b0; exp_err = 8'h00; exp_ovf = 8'h00;
    exp_rlen = 0; exp_rsrc = 8'h00; exp_rtype = 8'h00;
    held.delete();
  endtask

  always @(negedge clk) begin
    if (settled) begin
      chk("rrdy", {31'd0, rrdy}, {31'd0, exp_rrdy});
      chk("err_cnt", {24'd0, err_cnt}, {24'd0, exp_err});
      chk("ovf_cnt", {24'd0, ovf_cnt}, {24'd0, exp_ovf});
      chk("rlen", {{(32-LW){1'b0}}, rlen}, exp_rlen);
      if (exp_rrdy) begin
        chk("rsrc", {24'd0, rsrc}, {24'd0, exp_rsrc});
        chk("rtype", {24'd0, rtype}, {24'd0, exp_rtype});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int err_at, input bit fall_with_last);
    settled = 1'b0;
    SFD = 1'b1; cardet = 1'b1;
    tick();
    for (int i = 0; i < fr.size(); i++) begin
      write = 1'b1; data = fr[i]; error = (i == err_at);
      if (fall_with_last && i == fr.size() - 1) SFD = 1'b0;
      tick();
    end
    write = 1'b0; error = 1'b0; data = 8'h00; SFD = 1'b0; cardet = 1'b0;
    repeat (4) tick();
    model_frame(err_at);
    settled = 1'b1;
  endtask

  task automatic read_frame();
    int n;
    n = held.size();
    for (int i = 0; i < n; i++) begin
      chk("rdata", {24'd0, rdata}, {24'd0, held[i]});
      rrd = 1'b1;
      tick();
      rrd = 1'b0;
      if (i == n - 1) begin
        exp_rrdy = 1'b0;
        held.delete();
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cardet = 1'b0; SFD = 1'b0; write = 1'b0;
    error = 1'b0; rrd = 1'b0; data = 8'h00;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("reset_rrdy", {31'd0, rrdy}, 32'd0);
    chk("reset_rdata", {24'd0, rdata}, 32'd0);
    chk("reset_err", {24'd0, err_cnt}, 32'd0);
    chk("reset_ovf", {24'd0, ovf_cnt}, 32'd0);
    settled = 1'b1;

    // Basic frame, last byte coincident with SFD fall
    fr = {8'h07, 8'h11, 8'h22, 8'hAA, 8'hBB};
    send_frame(-1, 1'b1);
    chk("a_rrdy", {31'd0, rrdy}, 32'd1);
    chk("a_rlen", {{(32-LW){1'b0}}, rlen}, 32'd5);
    chk("a_rsrc", {24'd0, rsrc}, 32'h11);
    chk("a_rtype", {24'd0, rtype}, 32'h22);
    chk("a_byte0", {24'd0, rdata}, 32'h07);
    read_frame();
    chk("a_done", {31'd0, rrdy}, 32'd0);

    // Stray reads while nothing is held
    repeat (2) begin rrd = 1'b1; tick(); rrd = 1'b0; tick(); end

    // Broadcast accepted, foreign address ignored
    fr = {8'h2A, 8'h01, 8'h02, 8'h03};
    send_frame(-1, 1'b0);
    chk("bc_rlen", {{(32-LW){1'b0}}, rlen}, 32'd4);
    read_frame();
    fr = {8'h05, 8'h01, 8'h02, 8'h03};
    send_frame(-1, 1'b0);
    chk("foreign_rrdy", {31'd0, rrdy}, 32'd0);
    chk("foreign_err", {24'd0, err_cnt}, 32'd0);

    // Error, short frame, oversize frame, exact-depth frame
    fr = {8'h07, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(3, 1'b0);
    chk("err_pulse", {24'd0, err_cnt}, 32'd1);
    fr = {8'h07, 8'h01};
    send_frame(-1, 1'b0);
    chk("err_short", {24'd0, err_cnt}, 32'd2);
    fr.delete(); fr.push_back(8'h07);
    for (int i = 1; i < 65; i++) fr.push_back(8'(i * 3));
    send_frame(-1, 1'b0);
    chk("err_long", {24'd0, err_cnt}, 32'd3);
    fr.delete(); fr.push_back(8'h2A);
    for (int i = 1; i < 64; i++) fr.push_back(8'(255 - i));
    send_frame(-1, 1'b0);
    chk("full_rlen", {{(32-LW){1'b0}}, rlen}, 32'd64);
    read_frame();

    // Overflow while held; held frame intact
    fr = {8'h07, 8'h33, 8'h44, 8'h55};
    send_frame(-1, 1'b0);
    fr = {8'h07, 8'h66, 8'h77, 8'h88};
    send_frame(-1, 1'b0);
    chk("ovf_one", {24'd0, ovf_cnt}, 32'd1);
    chk("ovf_rsrc", {24'd0, rsrc}, 32'h33);
    read_frame();

    // Reset in the middle of a frame
    settled = 1'b0;
    SFD = 1'b1; cardet = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin write = 1'b1; data = 8'h07 + 8'(i); tick(); end
    reset = 1'b0; write = 1'b0; SFD = 1'b0; cardet = 1'b0; data = 8'h00;
    tick();
    model_reset();
    chk("rst_rrdy", {31'd0, rrdy}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_rlen", {{(32-LW){1'b0}}, rlen}, 32'd0);
    chk("rst_rsrc", {24'd0, rsrc}, 32'd0);
    chk("rst_rtype", {24'd0, rtype}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    chk("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
    reset = 1'b1;
    tick();
    settled = 1'b1;
    fr = {8'h2A, 8'h09, 8'h0A};
    send_frame(-1, 1'b0);
    chk("post_rst_rlen", {{(32-LW){1'b0}}, rlen}, 32'd3);
    read_frame();

    // Saturation of the error counter
    for (int k = 0; k < 256; k++) begin
      fr = {8'h07, 8'h01};
      send_frame(-1, 1'b0);
    end
    chk("err_sat", {24'd0, err_cnt}, 32'hFF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
